trdb_filter_ctrl: RTL and testbench

Parametrised, stateful instruction qualifier for the trace encoder. It generalises the per-field filter into NUM_CH identical comparator channels. Each channel can be pointed at any trace field and assigned a role: filter, start trigger or stop trigger. A start/stop window state machine and an optional qualified-instruction counter sit behind the channels. The block sits between the retire-port sampling stage and the encoder packet logic, and emits a registered `nc_qualified_o` per retired instruction.

---
 rtl/trdb_filter_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_trdb_filter_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trdb_filter_ctrl.sv
// Qualifies each retired instruction through NUM_CH comparator channels (filter/start/stop roles) and a start/stop window FSM.
// Latency: one cycle; all outputs are registered and reflect the instruction presented on the previous edge.
// Backpressure: none; a new instruction may be accepted every cycle and nothing ever stalls.
//
// Ports:
//   clk_i, rst_ni            clock and asynchronous active-low reset
//   trace_enable_i           global enable; low closes the window and clears the counter
//   valid_i                  one retired instruction this cycle
//   cause_i, tvec_i, tval_i, priv_lvl_i, iaddr_i   trace fields of that instruction
//   ch_field_i/ch_mode_i/ch_role_i/ch_lower_i/ch_upper_i   per-channel comparator configuration
//   stop_count_i             auto-close after this many qualified instructions (0 = never)
//   nc_qualified_o, qual_valid_o, window_open_o, qual_cnt_o   registered results
//
// Build option: define TRDB_FILTER_CNT_EN to include the qualified counter,
// its saturation and the stop_count_i auto-close. Without it qual_cnt_o is 0.
module trdb_filter_ctrl #(
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = 16,
  parameter int XLEN      = 32,
  parameter int CAUSE_LEN = 5
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   trace_enable_i,
  input  logic                   valid_i,
  input  logic [CAUSE_LEN-1:0]   cause_i,
  input  logic [XLEN-3:0]        tvec_i,
  input  logic [XLEN-1:0]        tval_i,
  input  logic [1:0]             priv_lvl_i,
  input  logic [XLEN-1:0]        iaddr_i,
  input  logic [NUM_CH*3-1:0]    ch_field_i,
  input  logic [NUM_CH*2-1:0]    ch_mode_i,
  input  logic [NUM_CH*2-1:0]    ch_role_i,
  input  logic [NUM_CH*XLEN-1:0] ch_lower_i,
  input  logic [NUM_CH*XLEN-1:0] ch_upper_i,
  input  logic [CNT_W-1:0]       stop_count_i,
  output logic                   nc_qualified_o,
  output logic                   qual_valid_o,
  output logic                   window_open_o,
  output logic [CNT_W-1:0]       qual_cnt_o
);

  localparam logic [1:0] ROLE_FILTER = 2'd1;
  localparam logic [1:0] ROLE_START  = 2'd2;
  localparam logic [1:0] ROLE_STOP   = 2'd3;

  typedef enum logic {CLOSED, OPEN} state_t;

  state_t state_q, state_d;

  // Normalised trace fields, all XLEN wide and compared unsigned.
  logic [XLEN-1:0] f_cause, f_tvec, f_priv;
  assign f_cause = XLEN'(cause_i);
  assign f_tvec  = {tvec_i, 2'b00};
  assign f_priv  = XLEN'(priv_lvl_i);

  // One comparator channel. Field selects 5..7 never hit. With lower > upper
  // the inclusive range is empty, so "inside" never hits and "outside" always does.
  function automatic logic ch_match(
    input logic [2:0]      sel,
    input logic [1:0]      mode,
    input logic [XLEN-1:0] lo,
    input logic [XLEN-1:0] up,
    input logic [XLEN-1:0] fc,
    input logic [XLEN-1:0] fv,
    input logic [XLEN-1:0] ft,
    input logic [XLEN-1:0] fp,
    input logic [XLEN-1:0] fa
  );
    logic [XLEN-1:0] f;
    logic            ok;
    logic            in_rng;
    logic            m;
    f  = '0;
    ok = 1'b1;
    case (sel)
      3'd0:    f = fc;
      3'd1:    f = fv;
      3'd2:    f = ft;
      3'd3:    f = fp;
      3'd4:    f = fa;
      default: ok = 1'b0;
    endcase
    in_rng = (f >= lo) && (f <= up);
    case (mode)
      2'd0:    m = (f == lo);
      2'd1:    m = in_rng;
      2'd2:    m = !in_rng;
      default: m = (((f ^ lo) & up) == '0);
    endcase
    return ok & m;
  endfunction

  logic filter_pass, start_any, stop_any, start_cfg;

  always_comb begin
    filter_pass = 1'b1;
    start_any   = 1'b0;
    stop_any    = 1'b0;
    start_cfg   = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      case (ch_role_i[c*2 +: 2])
        ROLE_FILTER: filter_pass = filter_pass &
                       ch_match(ch_field_i[c*3 +: 3], ch_mode_i[c*2 +: 2],
                                ch_lower_i[c*XLEN +: XLEN], ch_upper_i[c*XLEN +: XLEN],
                                f_cause, f_tvec, tval_i, f_priv, iaddr_i);
        ROLE_START: begin
          start_cfg = 1'b1;
          start_any = start_any |
                      ch_match(ch_field_i[c*3 +: 3], ch_mode_i[c*2 +: 2],
                               ch_lower_i[c*XLEN +: XLEN], ch_upper_i[c*XLEN +: XLEN],
                               f_cause, f_tvec, tval_i, f_priv, iaddr_i);
        end
        ROLE_STOP:   stop_any = stop_any |
                       ch_match(ch_field_i[c*3 +: 3], ch_mode_i[c*2 +: 2],
                                ch_lower_i[c*XLEN +: XLEN], ch_upper_i[c*XLEN +: XLEN],
                                f_cause, f_tvec, tval_i, f_priv, iaddr_i);
        default: ;
      endcase
    end
  end

  logic start_hit, stop_hit, in_window, qualified, open_take;

  assign start_hit = valid_i & start_any;
  assign stop_hit  = valid_i & stop_any;

  // Without any start channel the window is always open; otherwise the start
  // instruction itself is already in-window while the FSM is still CLOSED.
  assign in_window = !start_cfg || (state_q == OPEN) || start_hit;
  assign qualified = valid_i & trace_enable_i & in_window & filter_pass;

  // CLOSED -> OPEN transition requested this cycle (before auto-close).
  assign open_take = (state_q == CLOSED) && (!start_cfg || (start_hit && !stop_hit));

  logic auto_close;

`ifdef TRDB_FILTER_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_base, cnt_inc;
  logic             cnt_upd;

  // Counting restarts from zero on the instruction that opens the window.
  assign cnt_base   = (state_q == OPEN) ? cnt_q : '0;
  assign cnt_inc    = (qualified && (cnt_base != '1)) ? cnt_base + CNT_W'(1) : cnt_base;
  assign cnt_upd    = (state_q == OPEN) || open_take;
  assign auto_close = qualified && (stop_count_i != '0) && (cnt_inc == stop_count_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (!trace_enable_i) begin
      cnt_q <= '0;
    end else if (cnt_upd) begin
      cnt_q <= cnt_inc;
    end
  end

  assign qual_cnt_o = cnt_q;
`else
  logic unused_stop_count;
  assign unused_stop_count = ^stop_count_i;
  assign auto_close        = 1'b0;
  assign qual_cnt_o        = '0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= CLOSED;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!trace_enable_i) begin
      state_d = CLOSED;
    end else if (!start_cfg) begin
      state_d = OPEN;
    end else begin
      case (state_q)
        // Start and stop on the same instruction leaves the window closed.
        CLOSED:  if (open_take && !auto_close) state_d = OPEN;
        OPEN:    if (stop_hit || auto_close)   state_d = CLOSED;
        default: state_d = CLOSED;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      nc_qualified_o <= 1'b0;
      qual_valid_o   <= 1'b0;
    end else begin
      nc_qualified_o <= qualified;
      qual_valid_o   <= valid_i & trace_enable_i;
    end
  end

  assign window_open_o = (state_q == OPEN);

endmodule

// File: tb/tb_trdb_filter_ctrl.sv
module tb_trdb_filter_ctrl;

  localparam int NUM_CH    = 4;
  localparam int CNT_W     = 4;
  localparam int XLEN      = 32;
  localparam int CAUSE_LEN = 5;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;
`ifdef TRDB_FILTER_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   trace_en;
  logic                   valid;
  logic [CAUSE_LEN-1:0]   cause;
  logic [XLEN-3:0]        tvec;
  logic [XLEN-1:0]        tval;
  logic [1:0]             priv;
  logic [XLEN-1:0]        iaddr;
  logic [NUM_CH*3-1:0]    ch_field;
  logic [NUM_CH*2-1:0]    ch_mode;
  logic [NUM_CH*2-1:0]    ch_role;
  logic [NUM_CH*XLEN-1:0] ch_lower;
  logic [NUM_CH*XLEN-1:0] ch_upper;
  logic [CNT_W-1:0]       stop_count;
  logic                   nc_qualified;
  logic                   qual_valid;
  logic                   window_open;
  logic [CNT_W-1:0]       qual_cnt;

  always #5 clk = ~clk;

  trdb_filter_ctrl #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .XLEN(XLEN), .CAUSE_LEN(CAUSE_LEN)) dut (
    .clk_i(clk), .rst_ni(rst_n), .trace_enable_i(trace_en), .valid_i(valid),
    .cause_i(cause), .tvec_i(tvec), .tval_i(tval), .priv_lvl_i(priv), .iaddr_i(iaddr),
    .ch_field_i(ch_field), .ch_mode_i(ch_mode), .ch_role_i(ch_role),
    .ch_lower_i(ch_lower), .ch_upper_i(ch_upper), .stop_count_i(stop_count),
    .nc_qualified_o(nc_qualified), .qual_valid_o(qual_valid),
    .window_open_o(window_open), .qual_cnt_o(qual_cnt)
  );

  typedef struct {
    bit q;
    bit win;
    int cnt;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks   = 0;
  int   failures = 0;

  // Configuration as the bench sees it (unpacked, plain integers).
  int          cf_field[NUM_CH];
  int          cf_mode[NUM_CH];
  int          cf_role[NUM_CH];
  logic [31:0] cf_lo[NUM_CH];
  logic [31:0] cf_up[NUM_CH];

  // Reference window state.
  bit m_open;
  int m_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic apply_cfg();
    for (int c = 0; c < NUM_CH; c++) begin
      ch_field[c*3 +: 3]       = 3'(cf_field[c]);
      ch_mode[c*2 +: 2]        = 2'(cf_mode[c]);
      ch_role[c*2 +: 2]        = 2'(cf_role[c]);
      ch_lower[c*XLEN +: XLEN] = cf_lo[c];
      ch_upper[c*XLEN +: XLEN] = cf_up[c];
    end
  endtask

  task automatic clear_cfg();
    for (int c = 0; c < NUM_CH; c++) begin
      cf_field[c] = 0; cf_mode[c] = 0; cf_role[c] = 0; cf_lo[c] = '0; cf_up[c] = '0;
    end
  endtask

  function automatic bit m_hit(input int c);
    longint unsigned f, lo, up;
    case (cf_field[c])
      0: f = longint'(cause);
      1: f = longint'(tvec) * 4;
      2: f = longint'(tval);
      3: f = longint'(priv);
      4: f = longint'(iaddr);
      default: return 1'b0;
    endcase
    lo = longint'(cf_lo[c]);
    up = longint'(cf_up[c]);
    case (cf_mode[c])
      0: return f == lo;
      1: return (f >= lo) && (f <= up);
      2: return (f < lo) || (f > up);
      default: return ((f ^ lo) & up) == 0;
    endcase
  endfunction

  function automatic int sat(input int x);
    return (x > CNT_MAX) ? CNT_MAX : x;
  endfunction

  function automatic bit auto_hit(input bit q);
    return CNT_EN && (stop_count != 0) && q && (m_cnt == int'(stop_count));
  endfunction

  // Window rules written directly from the qualification behaviour.
  task automatic model_step(input bit v, input bit en);
    bit start_cfg = 1'b0;
    bit fp = 1'b1;
    bit sh = 1'b0;
    bit th = 1'b0;
    bit inwin, q;
    if (!en) begin
      m_open = 1'b0;
      m_cnt  = 0;
      return;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      case (cf_role[c])
        1: fp = fp && m_hit(c);
        2: begin start_cfg = 1'b1; sh = sh || (v && m_hit(c)); end
        3: th = th || (v && m_hit(c));
        default: ;
      endcase
    end
    inwin = !start_cfg || m_open || sh;
    q     = v && inwin && fp;
    if (!start_cfg) begin
      m_cnt  = m_open ? sat(m_cnt + int'(q)) : int'(q);
      m_open = 1'b1;
    end else if (!m_open) begin
      if (sh && !th) begin
        m_open = 1'b1;
        m_cnt  = int'(q);
        if (auto_hit(q)) m_open = 1'b0;
      end
    end else begin
      if (q) m_cnt = sat(m_cnt + 1);
      if (th || auto_hit(q)) m_open = 1'b0;
    end
    if (!CNT_EN) m_cnt = 0;
    if (v) sb.push_back('{q, m_open, m_cnt});
  endtask

  task automatic drive(input bit v, input bit en, input logic [31:0] ia);
    @(negedge clk);
    valid    = v;
    trace_en = en;
    iaddr    = ia;
    cause    = CAUSE_LEN'($urandom_range(0, 3));
    tvec     = 30'($urandom_range(0, 7));
    tval     = 32'($urandom_range(0, 15));
    priv     = 2'($urandom_range(0, 3));
    model_step(v, en);
  endtask

  // Reconfigure only with trace disabled.
  task automatic reconfig_idle();
    drive(1'b0, 1'b0, 32'h0);
    clear_cfg();
  endtask

  task automatic set_ch(input int c, input int role, input int field, input int mode,
                        input logic [31:0] lo, input logic [31:0] up);
    cf_role[c] = role; cf_field[c] = field; cf_mode[c] = mode; cf_lo[c] = lo; cf_up[c] = up;
  endtask

  // Monitor: pops one expectation per presented output.
  always @(posedge clk) begin
    #1;
    if (rst_n === 1'b1) begin
      if (qual_valid === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_qual_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("nc_qualified", nc_qualified, e.q);
          chk("window_open", window_open, e.win);
          chk("qual_cnt", qual_cnt, e.cnt);
        end
      end else begin
        chk("qualified_without_valid", nc_qualified, 0);
      end
    end
  end

  initial begin
    rst_n = 1'b0; trace_en = 1'b0; valid = 1'b0; cause = '0; tvec = '0; tval = '0;
    priv = '0; iaddr = '0; stop_count = '0;
    clear_cfg();
    apply_cfg();
    m_open = 1'b0; m_cnt = 0;
    #12;
    chk("reset_nc_qualified", nc_qualified, 0);
    chk("reset_qual_valid", qual_valid, 0);
    chk("reset_window_open", window_open, 0);
    chk("reset_qual_cnt", qual_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // No roles: every instruction qualifies.
    drive(1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 32'h40 + 32'(i * 4));

    // Range filter on iaddr with inclusive bounds.
    reconfig_idle();
    set_ch(0, 1, 4, 1, 32'h1000, 32'h1FFF);
    apply_cfg();
    drive(1'b1, 1'b1, 32'h0FFC);
    drive(1'b1, 1'b1, 32'h1000);
    drive(1'b1, 1'b1, 32'h1FFF);
    drive(1'b1, 1'b1, 32'h2000);

    // Start/stop window.
    reconfig_idle();
    set_ch(0, 2, 4, 0, 32'h100, 32'h0);
    set_ch(1, 3, 4, 0, 32'h200, 32'h0);
    apply_cfg();
    drive(1'b1, 1'b1, 32'h0FC);
    drive(1'b1, 1'b1, 32'h100);
    drive(1'b1, 1'b1, 32'h104);
    drive(1'b1, 1'b1, 32'h200);
    drive(1'b1, 1'b1, 32'h204);

    // Start and stop on the same instruction while closed.
    reconfig_idle();
    set_ch(0, 2, 4, 0, 32'h100, 32'h0);
    set_ch(1, 3, 4, 0, 32'h100, 32'h0);
    apply_cfg();
    drive(1'b1, 1'b1, 32'h100);
    drive(1'b1, 1'b1, 32'h104);
    drive(1'b1, 1'b1, 32'h108);

    // Auto-close after three qualified instructions.
    reconfig_idle();
    set_ch(0, 2, 4, 0, 32'h100, 32'h0);
    apply_cfg();
    stop_count = CNT_W'(3);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 32'h100 + 32'(i * 4));

    // Counter saturation with the window permanently open.
    reconfig_idle();
    apply_cfg();
    stop_count = '0;
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, 32'h300);

    // Asynchronous reset while open with a count of 7.
    reconfig_idle();
    set_ch(0, 2, 4, 0, 32'h100, 32'h0);
    apply_cfg();
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b1, 32'h100 + 32'(i * 4));
    drive(1'b0, 1'b1, 32'h0);
    drive(1'b0, 1'b1, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_nc_qualified", nc_qualified, 0);
    chk("async_rst_qual_valid", qual_valid, 0);
    chk("async_rst_window_open", window_open, 0);
    chk("async_rst_qual_cnt", qual_cnt, 0);
    m_open = 1'b0;
    m_cnt  = 0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 32'h104);
    drive(1'b1, 1'b1, 32'h100);
    drive(1'b1, 1'b1, 32'h104);

    // Randomised configurations and streams.
    for (int r = 0; r < 12; r++) begin
      reconfig_idle();
      for (int c = 0; c < NUM_CH; c++) begin
        cf_role[c]  = $urandom_range(0, 3);
        cf_field[c] = $urandom_range(0, 7);
        cf_mode[c]  = $urandom_range(0, 3);
        if (cf_field[c] == 4) begin
          cf_lo[c] = 32'h100 + 32'($urandom_range(0, 15) * 4);
          cf_up[c] = 32'h100 + 32'($urandom_range(0, 15) * 4);
        end else begin
          cf_lo[c] = 32'($urandom_range(0, 15));
          cf_up[c] = 32'($urandom_range(0, 15));
        end
      end
      apply_cfg();
      stop_count = CNT_W'($urandom_range(0, 4));
      for (int i = 0; i < 40; i++)
        drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) != 0),
              32'h100 + 32'($urandom_range(0, 15) * 4));
    end

    drive(1'b0, 1'b1, 32'h0);
    drive(1'b0, 1'b1, 32'h0);
    drive(1'b0, 1'b1, 32'h0);
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
